// File: rtl/mmio_pwm_pkg.sv
// Shared constants for the memory-mapped PWM peripheral: register offsets,
// CTRL bit positions and the accepted store size.
package mmio_pwm_pkg;

   localparam logic [4:0] OFF_CTRL     = 5'h00;
   localparam logic [4:0] OFF_PRESCALE = 5'h04;
   localparam logic [4:0] OFF_PERIOD   = 5'h08;
   localparam logic [4:0] OFF_STATUS   = 5'h0C;
   localparam logic [4:0] OFF_DUTY0    = 5'h10;

   localparam int EN_BIT  = 0;
   localparam int INV_BIT = 1;

   localparam logic [2:0] FUNCT3_SW = 3'b010;

   // Byte offset of the DUTY register belonging to channel ch.
   function automatic logic [4:0] duty_off(input int ch);
      return 5'(int'(OFF_DUTY0) + 4 * ch);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and period counter; emits the prescaled tick and the wrap pulse
// that marks a period boundary.
module pwm_timebase #(
   parameter int CNT_W = 16,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [PRE_W-1:0] prescale,
   input  logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             wrap
);

   logic [PRE_W-1:0] pre_reg;
   logic [CNT_W-1:0] cnt_reg;

   assign tick = en && (pre_reg == prescale);
   assign wrap = tick && (cnt_reg == period);
   assign cnt  = cnt_reg;

   // A prescale lowered below the running count lets pre roll over at 2^PRE_W.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_reg <= '0;
      end else if (!en || tick) begin
         pre_reg <= '0;
      end else begin
         pre_reg <= pre_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (!en || wrap) begin
         cnt_reg <= '0;
      end else if (tick) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_pwm.sv
// Memory-mapped multi-channel PWM: register file with double-buffered
// period/duty, sticky wrap status and registered duty comparators.
module mmio_pwm
   import mmio_pwm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF40,
   parameter int          NUM_CH    = 4,
   parameter int          CNT_W     = 16,
   parameter int          PRE_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              hit,
   output logic [NUM_CH-1:0] pwm
);

   logic [1:0]        ctrl_reg;
   logic [PRE_W-1:0]  prescale_reg;
   logic [CNT_W-1:0]  period_reg;
   logic [CNT_W-1:0]  act_period_reg;
   logic              wrap_flag_reg;
   logic [CNT_W-1:0]  duty_rd [NUM_CH];
   logic [NUM_CH-1:0] pwm_reg;

   logic              wr_en;
   logic [4:0]        word_off;
   logic              en;
   logic              inv;
   logic [CNT_W-1:0]  cnt;
   logic              tick;
   logic              wrap;
   logic              act_load;
   logic              unused_bits;

   assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
   assign wr_en       = mem_write && hit && (funct3 == FUNCT3_SW);
   assign word_off    = {addr[4:2], 2'b00};
   assign en          = ctrl_reg[EN_BIT];
   assign inv         = ctrl_reg[INV_BIT];
   assign act_load    = !en || wrap;
   assign pwm         = pwm_reg;
   assign unused_bits = ^{addr[1:0], wdata[31:CNT_W], tick};

   pwm_timebase #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
   ) u_timebase (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .prescale (prescale_reg),
      .period   (act_period_reg),
      .cnt      (cnt),
      .tick     (tick),
      .wrap     (wrap)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_reg     <= '0;
         prescale_reg <= '0;
         period_reg   <= '0;
      end else if (wr_en) begin
         if (word_off == OFF_CTRL)     ctrl_reg     <= wdata[1:0];
         if (word_off == OFF_PRESCALE) prescale_reg <= wdata[PRE_W-1:0];
         if (word_off == OFF_PERIOD)   period_reg   <= wdata[CNT_W-1:0];
      end
   end

   // Active copies follow the shadows while idle, and latch the pre-write
   // shadow on a wrap so a same-edge write lands one period later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         act_period_reg <= '0;
      end else if (act_load) begin
         act_period_reg <= period_reg;
      end
   end

   // A wrap on the same edge as a clearing write keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wrap_flag_reg <= 1'b0;
      end else if (wrap) begin
         wrap_flag_reg <= 1'b1;
      end else if (wr_en && (word_off == OFF_STATUS) && wdata[0]) begin
         wrap_flag_reg <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] duty_reg;
         logic [CNT_W-1:0] act_duty_reg;

         assign duty_rd[gi] = duty_reg;

         always_ff @(posedge clk) begin
            if (!reset) begin
               duty_reg <= '0;
            end else if (wr_en && (word_off == duty_off(gi))) begin
               duty_reg <= wdata[CNT_W-1:0];
            end
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               act_duty_reg <= '0;
            end else if (act_load) begin
               act_duty_reg <= duty_reg;
            end
         end

         // Duty above the active period keeps the compare true all period long.
         always_ff @(posedge clk) begin
            if (!reset) begin
               pwm_reg[gi] <= 1'b0;
            end else begin
               pwm_reg[gi] <= en & (inv ^ (cnt < act_duty_reg));
            end
         end
      end
   endgenerate

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (word_off)
            OFF_CTRL:     rdata[1:0]       = ctrl_reg;
            OFF_PRESCALE: rdata[PRE_W-1:0] = prescale_reg;
            OFF_PERIOD:   rdata[CNT_W-1:0] = period_reg;
            OFF_STATUS:   rdata[0]         = wrap_flag_reg;
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (word_off == duty_off(i)) rdata[CNT_W-1:0] = duty_rd[i];
               end
            end
         endcase
      end
   end

endmodule
